// File: rtl/conv_pool_engine.sv
// conv_pool_engine: serially loaded KxK zero-padded stride-1 convolution, one MAC per cycle,
// followed by 2x2/stride-2 max pooling. Define RELU_EN to clamp negative conv values to 0 before pooling.
module conv_pool_engine #(
  parameter int DW   = 16,
  parameter int FRT  = 14,
  parameter int PAD  = 0,
  parameter int K    = 3,
  parameter int FRAC = 0,
  parameter int AW   = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          w_load,
  input  logic [DW-1:0] w_in,
  input  logic          i_load,
  input  logic [DW-1:0] i_in,
  output logic [DW-1:0] pool_result,
  output logic [AW-1:0] addr,
  output logic [1:0]    history,
  output logic          pool_valid,
  output logic          busy,
  output logic          com_end
);

  localparam int O     = FRT + 2*PAD - K + 1;
  localparam int P     = O / 2;
  localparam int KK    = K * K;
  localparam int NPIX  = FRT * FRT;
  localparam int NPOOL = P * P;
  localparam int KW    = (KK > 1) ? $clog2(KK) : 1;
  localparam int IW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PW    = (P > 1) ? $clog2(P) : 1;
  localparam int OW    = (NPOOL > 1) ? $clog2(NPOOL) : 1;
  localparam int ACCW  = 2*DW + $clog2(KK);
  localparam int LW    = IW + $clog2(PAD + K + 1) + 2;

  localparam logic signed [LW-1:0]   FRT_L   = LW'(FRT);
  localparam logic signed [LW-1:0]   PAD_L   = LW'(PAD);
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [DW-1:0]   MAX_DW  = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   MIN_DW  = ~MAX_DW;

  typedef enum logic [2:0] {IDLE, LOAD, CONV, POOL, DONE} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          wcnt_q, wcnt_d;
  logic [IW-1:0]          icnt_q, icnt_d;
  logic [KW-1:0]          kidx_q, kidx_d, kr_q, kr_d, kc_q, kc_d;
  logic [1:0]             quad_q, quad_d;
  logic [PW-1:0]          px_q, px_d, py_q, py_d;
  logic [OW-1:0]          ocnt_q, ocnt_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [DW-1:0]   max_q, max_d;
  logic [1:0]             hist_q, hist_d;
  logic [DW-1:0]          res_q, res_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [1:0]             histo_q, histo_d;

  logic signed [DW-1:0]   weight_mem [KK];
  logic signed [DW-1:0]   pixel_mem  [NPIX];

  logic                   load_ph, w_we, i_we, in_rng, better;
  logic signed [LW-1:0]   oy, ox, r, c;
  logic [IW-1:0]          pix_idx;
  logic signed [DW-1:0]   pix, conv_val, pool_val;
  logic [1:0]             pool_hist;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] acc_sum, shifted;

  assign load_ph = (state_q == IDLE) || (state_q == LOAD);
  assign w_we    = load_ph && w_load;
  assign i_we    = load_ph && i_load && !w_load;

  always_ff @(posedge clk) begin
    if (w_we) weight_mem[wcnt_q] <= w_in;
    if (i_we) pixel_mem[icnt_q]  <= i_in;
  end

  // Tap address: conv position from pooled coord + quadrant, then shifted by kernel offset minus padding.
  always_comb begin
    oy      = $signed(LW'({py_q, quad_q[1]}));
    ox      = $signed(LW'({px_q, quad_q[0]}));
    r       = oy + $signed(LW'(kr_q)) - PAD_L;
    c       = ox + $signed(LW'(kc_q)) - PAD_L;
    in_rng  = !r[LW-1] && (r < FRT_L) && !c[LW-1] && (c < FRT_L);
    pix_idx = IW'(r * FRT_L + c);
    pix     = in_rng ? pixel_mem[pix_idx] : '0;
    prod    = weight_mem[kidx_q] * pix;
    acc_sum = ((kidx_q == '0) ? '0 : acc_q) + ACCW'(prod);
    shifted = acc_sum >>> FRAC;
    if (shifted > SAT_MAX)      conv_val = MAX_DW;
    else if (shifted < SAT_MIN) conv_val = MIN_DW;
    else                        conv_val = shifted[DW-1:0];
`ifdef RELU_EN
    if (conv_val[DW-1]) conv_val = '0;
`endif
    better    = (quad_q == 2'd0) || (conv_val > max_q);
    pool_val  = better ? conv_val : max_q;
    pool_hist = better ? quad_q : hist_q;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    icnt_d  = icnt_q;
    kidx_d  = kidx_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    quad_d  = quad_q;
    px_d    = px_q;
    py_d    = py_q;
    ocnt_d  = ocnt_q;
    acc_d   = acc_q;
    max_d   = max_q;
    hist_d  = hist_q;
    res_d   = res_q;
    addr_d  = addr_q;
    histo_d = histo_q;
    case (state_q)
      IDLE, LOAD: begin
        if (w_load) begin
          wcnt_d = (wcnt_q == KW'(KK-1)) ? '0 : wcnt_q + 1'b1;
        end else if (i_load) begin
          state_d = LOAD;
          if (icnt_q == IW'(NPIX-1)) begin
            icnt_d  = '0;
            state_d = CONV;
          end else begin
            icnt_d = icnt_q + 1'b1;
          end
        end
      end
      CONV: begin
        acc_d  = acc_sum;
        kidx_d = kidx_q + 1'b1;
        if (kc_q == KW'(K-1)) begin
          kc_d = '0;
          kr_d = kr_q + 1'b1;
        end else begin
          kc_d = kc_q + 1'b1;
        end
        // The BR conv value completes the window, so the pooled result is latched on its last tap.
        if (kidx_q == KW'(KK-1)) begin
          kidx_d = '0;
          kr_d   = '0;
          kc_d   = '0;
          quad_d = quad_q + 1'b1;
          max_d  = pool_val;
          hist_d = pool_hist;
          if (quad_q == 2'd3) begin
            state_d = POOL;
            res_d   = pool_val;
            histo_d = pool_hist;
            addr_d  = AW'(ocnt_q);
          end
        end
      end
      POOL: begin
        if (ocnt_q == OW'(NPOOL-1)) begin
          state_d = DONE;
          ocnt_d  = '0;
          px_d    = '0;
          py_d    = '0;
        end else begin
          state_d = CONV;
          ocnt_d  = ocnt_q + 1'b1;
          if (px_q == PW'(P-1)) begin
            px_d = '0;
            py_d = py_q + 1'b1;
          end else begin
            px_d = px_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      icnt_q  <= '0;
      kidx_q  <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      quad_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      ocnt_q  <= '0;
      acc_q   <= '0;
      max_q   <= '0;
      hist_q  <= '0;
      res_q   <= '0;
      addr_q  <= '0;
      histo_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      icnt_q  <= icnt_d;
      kidx_q  <= kidx_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      quad_q  <= quad_d;
      px_q    <= px_d;
      py_q    <= py_d;
      ocnt_q  <= ocnt_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      hist_q  <= hist_d;
      res_q   <= res_d;
      addr_q  <= addr_d;
      histo_q <= histo_d;
    end
  end

  assign pool_result = res_q;
  assign addr        = addr_q;
  assign history     = histo_q;
  assign pool_valid  = (state_q == POOL);
  assign busy        = (state_q == CONV) || (state_q == POOL);
  assign com_end     = (state_q == DONE);

endmodule

// File: tb/tb_conv_pool_engine.sv
// Scoreboard bench for conv_pool_engine: a default 14x14 instance and a padded 4x4 instance.
module tb_conv_pool_engine;

  typedef struct {
    int res;
    int adr;
    int hist;
    int cyc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        w_load = 1'b0, i_load = 1'b0;
  logic [15:0] w_in = '0, i_in = '0;
  logic [15:0] pool_result, addr;
  logic [1:0]  history;
  logic        pool_valid, busy, com_end;

  logic        b_w_load = 1'b0, b_i_load = 1'b0;
  logic [15:0] b_w_in = '0, b_i_in = '0;
  logic [15:0] b_pool_result, b_addr;
  logic [1:0]  b_history;
  logic        b_pool_valid, b_busy, b_com_end;

  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   tw [9];
  int   tp [196];
  ent_t exp_q[$], obs_q[$], pobs_q[$];
  int   com_q[$], pcom_q[$];
  ent_t m, pm;

  conv_pool_engine u_dut (
    .clk(clk), .reset_n(reset_n), .w_load(w_load), .w_in(w_in), .i_load(i_load), .i_in(i_in),
    .pool_result(pool_result), .addr(addr), .history(history), .pool_valid(pool_valid),
    .busy(busy), .com_end(com_end)
  );

  conv_pool_engine #(.DW(16), .FRT(4), .PAD(1), .K(3), .FRAC(0), .AW(16)) u_pad (
    .clk(clk), .reset_n(reset_n), .w_load(b_w_load), .w_in(b_w_in), .i_load(b_i_load), .i_in(b_i_in),
    .pool_result(b_pool_result), .addr(b_addr), .history(b_history), .pool_valid(b_pool_valid),
    .busy(b_busy), .com_end(b_com_end)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pool_valid === 1'b1) begin
      m.res = int'($signed(pool_result)); m.adr = int'(addr); m.hist = int'(history); m.cyc = cyc;
      obs_q.push_back(m);
    end
    if (com_end === 1'b1) com_q.push_back(cyc);
    if (b_pool_valid === 1'b1) begin
      pm.res = int'($signed(b_pool_result)); pm.adr = int'(b_addr); pm.hist = int'(b_history); pm.cyc = cyc;
      pobs_q.push_back(pm);
    end
    if (b_com_end === 1'b1) pcom_q.push_back(cyc);
  end

  // Reference: direct 3x3 zero-padded convolution, 16-bit saturation, 2x2 max with first-wins ties.
  function automatic void model(input int frt, input int pad, input int idx, output int val, output int hist);
    int p, py, px, oy, ox, r, c, v, best, bh;
    longint acc;
    p = (frt + 2*pad - 2) / 2;
    py = idx / p; px = idx % p;
    best = 0; bh = 0;
    for (int q = 0; q < 4; q++) begin
      oy = 2*py + q/2; ox = 2*px + q%2; acc = 0;
      for (int kr = 0; kr < 3; kr++)
        for (int kc = 0; kc < 3; kc++) begin
          r = oy + kr - pad; c = ox + kc - pad;
          if (r >= 0 && r < frt && c >= 0 && c < frt)
            acc += longint'(tw[kr*3+kc]) * longint'(tp[r*frt+c]);
        end
      if (acc > 32767) v = 32767;
      else if (acc < -32768) v = -32768;
      else v = int'(acc);
`ifdef RELU_EN
      if (v < 0) v = 0;
`endif
      if (q == 0 || v > best) begin best = v; bh = q; end
    end
    val = best; hist = bh;
  endfunction

  task automatic load_main(input bit both, input bit hold, input bit push);
    ent_t e;
    int v, h;
    obs_q.delete(); com_q.delete(); exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      w_load = 1'b1; w_in = 16'(tw[i]); i_load = both; i_in = 16'h5A5A;
    end
    for (int i = 0; i < 196; i++) begin
      @(posedge clk); #1;
      w_load = 1'b0; i_load = 1'b1; i_in = 16'(tp[i]); last_acc = cyc;
    end
    @(posedge clk); #1;
    i_in = 16'h7777;
    if (hold) begin repeat (100) @(posedge clk); #1; end
    i_load = 1'b0;
    if (push)
      for (int idx = 0; idx < 36; idx++) begin
        model(14, 0, idx, v, h);
        e.res = v; e.adr = idx; e.hist = h; e.cyc = last_acc + 37*(idx+1);
        exp_q.push_back(e);
      end
  endtask

  task automatic wait_com(input int bound, input bit pad);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (pad ? (pcom_q.size() > 0) : (com_q.size() > 0)) break;
    end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({pool_valid, busy, com_end} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 000", {pool_valid, busy, com_end});
    end
    n_cmp++;
    if ({pool_result, addr, history} !== 34'h0) begin
      n_bad++; $display("FAIL reset_data got %h/%h/%h want 0", pool_result, addr, history);
    end
    n_cmp++;
    if ({b_pool_valid, b_busy, b_com_end, b_pool_result} !== 19'h0) begin
      n_bad++; $display("FAIL reset_pad got %b%b%b %h want 0", b_pool_valid, b_busy, b_com_end, b_pool_result);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_ramp();
    ent_t e, o, first, last;
    first.res = -1; first.hist = -1; last.res = -1; last.hist = -1; last.cyc = -1;
    for (int i = 0; i < 9; i++) tw[i] = i + 1;
    for (int i = 0; i < 196; i++) tp[i] = i + 1;
    load_main(1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL ramp_busy got %b want 1", busy); end
    wait_com(3000, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL ramp_strobe addr %0d missing", e.adr); end
      else begin
        o = obs_q.pop_front();
        if (e.adr == 0) first = o;
        if (e.adr == 35) last = o;
        if (o.res !== e.res || o.adr !== e.adr || o.hist !== e.hist || o.cyc !== e.cyc) begin
          n_bad++;
          $display("FAIL ramp_strobe got res %0d addr %0d hist %0d cyc %0d want res %0d addr %0d hist %0d cyc %0d",
                   o.res, o.adr, o.hist, o.cyc, e.res, e.adr, e.hist, e.cyc);
        end
      end
    end
    n_cmp++;
    if (first.res !== 1653 || first.hist !== 3) begin
      n_bad++; $display("FAIL ramp_addr0 got %0d/%0d want 1653/3", first.res, first.hist);
    end
    n_cmp++;
    if (last.res !== 8403 || last.hist !== 3) begin
      n_bad++; $display("FAIL ramp_addr35 got %0d/%0d want 8403/3", last.res, last.hist);
    end
    n_cmp++;
    if (obs_q.size() !== 0) begin n_bad++; $display("FAIL ramp_extra got %0d extra strobes want 0", obs_q.size()); end
    n_cmp++;
    if (com_q.size() !== 1 || com_q[0] !== last_acc + 37*36 + 1) begin
      n_bad++; $display("FAIL ramp_com_end got %0d pulses first at %0d want 1 at %0d",
                        com_q.size(), (com_q.size() > 0) ? com_q[0] : -1, last_acc + 37*36 + 1);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL ramp_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_pad();
    ent_t e, o;
    int v, h;
    int hexp [4];
    hexp[0] = 3; hexp[1] = 2; hexp[2] = 1; hexp[3] = 0;
    for (int i = 0; i < 9; i++) tw[i] = 1;
    for (int i = 0; i < 16; i++) tp[i] = 1;
    pobs_q.delete(); pcom_q.delete(); exp_q.delete();
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; b_w_load = 1'b1; b_w_in = 16'(tw[i]); end
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1; b_w_load = 1'b0; b_i_load = 1'b1; b_i_in = 16'(tp[i]); last_acc = cyc;
    end
    @(posedge clk); #1; b_i_load = 1'b0;
    for (int idx = 0; idx < 4; idx++) begin
      model(4, 1, idx, v, h);
      e.res = v; e.adr = idx; e.hist = h; e.cyc = last_acc + 37*(idx+1);
      exp_q.push_back(e);
    end
    wait_com(400, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (pobs_q.size() == 0) begin n_bad++; $display("FAIL pad_strobe addr %0d missing", e.adr); end
      else begin
        o = pobs_q.pop_front();
        if (o.res !== e.res || o.adr !== e.adr || o.hist !== e.hist || o.cyc !== e.cyc ||
            o.res !== 9 || o.hist !== hexp[e.adr]) begin
          n_bad++;
          $display("FAIL pad_strobe got res %0d addr %0d hist %0d cyc %0d want res 9 addr %0d hist %0d cyc %0d",
                   o.res, o.adr, o.hist, o.cyc, e.adr, hexp[e.adr], e.cyc);
        end
      end
    end
    n_cmp++;
    if (pcom_q.size() !== 1 || pobs_q.size() !== 0) begin
      n_bad++; $display("FAIL pad_end got %0d com_end %0d extra want 1/0", pcom_q.size(), pobs_q.size());
    end
  endtask

  task automatic test_neg();
    ent_t e, o, first;
    first.res = 12345; first.hist = -1;
    for (int i = 0; i < 9; i++) tw[i] = -1;
    for (int i = 0; i < 196; i++) tp[i] = i + 1;
    load_main(1'b0, 1'b0, 1'b1);
    wait_com(3000, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL neg_strobe addr %0d missing", e.adr); end
      else begin
        o = obs_q.pop_front();
        if (e.adr == 0) first = o;
        if (o.res !== e.res || o.adr !== e.adr || o.hist !== e.hist || o.cyc !== e.cyc || o.hist !== 0) begin
          n_bad++;
          $display("FAIL neg_strobe got res %0d addr %0d hist %0d cyc %0d want res %0d addr %0d hist 0 cyc %0d",
                   o.res, o.adr, o.hist, o.cyc, e.res, e.adr, e.cyc);
        end
      end
    end
    n_cmp++;
`ifdef RELU_EN
    if (first.res !== 0) begin n_bad++; $display("FAIL neg_addr0 got %0d want 0", first.res); end
`else
    if (first.res !== -144) begin n_bad++; $display("FAIL neg_addr0 got %0d want -144", first.res); end
`endif
  endtask

  task automatic test_sat();
    ent_t e, o;
    for (int i = 0; i < 9; i++) tw[i] = 32767;
    for (int i = 0; i < 196; i++) tp[i] = 32767;
    load_main(1'b0, 1'b0, 1'b1);
    wait_com(3000, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL sat_strobe addr %0d missing", e.adr); end
      else begin
        o = obs_q.pop_front();
        if (o.res !== e.res || o.res !== 32767 || o.adr !== e.adr || o.hist !== e.hist || o.cyc !== e.cyc) begin
          n_bad++;
          $display("FAIL sat_strobe got res %0d addr %0d hist %0d cyc %0d want res 32767 addr %0d hist %0d cyc %0d",
                   o.res, o.adr, o.hist, o.cyc, e.adr, e.hist, e.cyc);
        end
      end
    end
    n_cmp++;
    if (com_q.size() !== 1) begin n_bad++; $display("FAIL sat_com_end got %0d want 1", com_q.size()); end
  endtask

  task automatic test_reset_mid();
    ent_t e, o;
    for (int i = 0; i < 9; i++) tw[i] = i + 1;
    for (int i = 0; i < 196; i++) tp[i] = i + 1;
    load_main(1'b0, 1'b0, 1'b0);
    repeat (50) @(posedge clk);
    #1; reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({pool_valid, busy, com_end, pool_result, addr, history} !== 37'h0) begin
      n_bad++; $display("FAIL midreset_outputs got %b%b%b %h %h %h want 0",
                        pool_valid, busy, com_end, pool_result, addr, history);
    end
    obs_q.delete(); com_q.delete();
    @(posedge clk); #1; reset_n = 1'b1;
    repeat (1500) @(posedge clk);
    n_cmp++;
    if (obs_q.size() !== 0 || com_q.size() !== 0) begin
      n_bad++; $display("FAIL midreset_quiet got %0d strobes %0d com_end want 0/0", obs_q.size(), com_q.size());
    end
    load_main(1'b0, 1'b0, 1'b1);
    wait_com(3000, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL midreset_strobe addr %0d missing", e.adr); end
      else begin
        o = obs_q.pop_front();
        if (o.res !== e.res || o.adr !== e.adr || o.hist !== e.hist || o.cyc !== e.cyc) begin
          n_bad++;
          $display("FAIL midreset_strobe got res %0d addr %0d hist %0d cyc %0d want res %0d addr %0d hist %0d cyc %0d",
                   o.res, o.adr, o.hist, o.cyc, e.res, e.adr, e.hist, e.cyc);
        end
      end
    end
  endtask

  task automatic test_priority();
    ent_t e, o;
    for (int i = 0; i < 9; i++) tw[i] = i + 1;
    for (int i = 0; i < 196; i++) tp[i] = i + 1;
    load_main(1'b1, 1'b0, 1'b1);
    wait_com(3000, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL prio_strobe addr %0d missing", e.adr); end
      else begin
        o = obs_q.pop_front();
        if (o.res !== e.res || o.adr !== e.adr || o.hist !== e.hist || o.cyc !== e.cyc) begin
          n_bad++;
          $display("FAIL prio_strobe got res %0d addr %0d hist %0d cyc %0d want res %0d addr %0d hist %0d cyc %0d",
                   o.res, o.adr, o.hist, o.cyc, e.res, e.adr, e.hist, e.cyc);
        end
      end
    end
    n_cmp++;
    if (com_q.size() !== 1 || obs_q.size() !== 0) begin
      n_bad++; $display("FAIL prio_end got %0d com_end %0d extra want 1/0", com_q.size(), obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_pad();
    test_neg();
    test_sat();
    test_reset_mid();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d want completion", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
